// File: rtl/mc_control_unit.sv
// Multicycle MIPS-subset control unit: Moore FSM driving datapath strobes and muxes.
// Latency: outputs are registered and track the state register; FETCH/MRD last MEM_WAIT cycles.
// Backpressure: none; memory is modelled as a fixed MEM_WAIT-cycle read.
// Optional: define EXC_SUPPORT_EN to add the EXC state (illegal opcode / overflow trap).
module mc_control_unit #(
    parameter int MEM_WAIT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OPCode,
    input  logic [5:0] Funct,
    input  logic       Of,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNe,
    output logic [1:0] PCSource,
    output logic [2:0] IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       LoadA,
    output logic       LoadB,
    output logic       ALUOutWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] RegDst,
    output logic       MemToReg,
    output logic       RegWrite,
    output logic       EPCWrite,
    output logic [1:0] exc_cause,
    output logic       rst_out
);

    // Last counter value of a memory wait phase (MEM_WAIT legal range 1..7).
    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT - 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_RST   = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    localparam logic [2:0] ALU_IDLE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;

    // R-type execute and branch are split per operation so every output
    // is a pure function of the state register.
    typedef enum logic [4:0] {
        S_RST,
        S_FETCH,
        S_IRLD,
        S_DECODE,
        S_EXEC_ADD,
        S_EXEC_SUB,
        S_EXEC_AND,
        S_EXEC_I,
        S_WB_R,
        S_WB_I,
        S_BR_EQ,
        S_BR_NE,
        S_JUMP,
        S_MADDR,
        S_MRD,
        S_WB_L,
        S_MWR
`ifdef EXC_SUPPORT_EN
        , S_EXC
`endif
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_source;
        logic [2:0] iord;
        logic       mem_write;
        logic       ir_write;
        logic       load_a;
        logic       load_b;
        logic       alu_out_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       epc_write;
        logic       rst_out;
    } ctrl_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    ctrl_t      ctrl_q;
    logic       illegal_op;

`ifdef EXC_SUPPORT_EN
    logic [1:0] exc_q, exc_d;
`else
    logic       unused_of;
    assign unused_of = Of;
`endif

    // Moore output table: anything not named for a state stays 0.
    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_RST: c.rst_out = 1'b1;
            S_FETCH: begin
                c.iord      = 3'b000;
                c.alu_src_a = 1'b0;
                c.alu_src_b = 2'b01;
                c.alu_op    = ALU_ADD;
            end
            S_IRLD: begin
                c.iord      = 3'b000;
                c.alu_src_a = 1'b0;
                c.alu_src_b = 2'b01;
                c.alu_op    = ALU_ADD;
                c.pc_write  = 1'b1;
                c.pc_source = 2'b00;
                c.ir_write  = 1'b1;
            end
            S_DECODE: begin
                c.load_a        = 1'b1;
                c.load_b        = 1'b1;
                c.alu_src_a     = 1'b0;
                c.alu_src_b     = 2'b11;
                c.alu_op        = ALU_ADD;
                c.alu_out_write = 1'b1;
            end
            S_EXEC_ADD, S_EXEC_SUB, S_EXEC_AND: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = 2'b00;
                c.alu_out_write = 1'b1;
                c.alu_op        = (s == S_EXEC_ADD) ? ALU_ADD :
                                  (s == S_EXEC_SUB) ? ALU_SUB : ALU_AND;
            end
            S_EXEC_I, S_MADDR: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = 2'b10;
                c.alu_op        = ALU_ADD;
                c.alu_out_write = 1'b1;
            end
            S_WB_R: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 2'b01;
            end
            S_WB_I: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 2'b00;
            end
            S_BR_EQ, S_BR_NE: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = 2'b00;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                c.branch_ne     = (s == S_BR_NE);
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            S_MRD: c.iord = 3'b001;
            S_WB_L: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 2'b00;
                c.mem_to_reg = 1'b1;
            end
            S_MWR: begin
                c.iord      = 3'b001;
                c.mem_write = 1'b1;
            end
`ifdef EXC_SUPPORT_EN
            S_EXC: begin
                c.epc_write = 1'b1;
                c.pc_write  = 1'b1;
                c.pc_source = 2'b11;
            end
`endif
            default: c.alu_op = ALU_IDLE;
        endcase
        return c;
    endfunction

    // Next-state logic; the wait counter is zero on every entry into FETCH or MRD.
    always_comb begin
        state_d    = state_q;
        cnt_d      = 3'd0;
        illegal_op = 1'b0;
`ifdef EXC_SUPPORT_EN
        exc_d      = exc_q;
`endif
        case (state_q)
            S_RST:  state_d = S_FETCH;
            S_FETCH: begin
                if (cnt_q == WAIT_LAST) state_d = S_IRLD;
                else                    cnt_d   = cnt_q + 3'd1;
            end
            S_IRLD: state_d = S_DECODE;
            S_DECODE: begin
                case (OPCode)
                    OP_RTYPE: begin
                        case (Funct)
                            FN_ADD:  state_d = S_EXEC_ADD;
                            FN_SUB:  state_d = S_EXEC_SUB;
                            FN_AND:  state_d = S_EXEC_AND;
                            default: illegal_op = 1'b1;
                        endcase
                    end
                    OP_ADDI:      state_d = S_EXEC_I;
                    OP_BEQ:       state_d = S_BR_EQ;
                    OP_BNE:       state_d = S_BR_NE;
                    OP_J:         state_d = S_JUMP;
                    OP_LW, OP_SW: state_d = S_MADDR;
                    OP_RST:       state_d = S_RST;
                    default:      illegal_op = 1'b1;
                endcase
            end
`ifdef EXC_SUPPORT_EN
            S_EXEC_ADD, S_EXEC_SUB: begin
                if (Of) begin
                    state_d = S_EXC;
                    exc_d   = 2'b10;
                end else begin
                    state_d = S_WB_R;
                end
            end
            S_EXEC_I: begin
                if (Of) begin
                    state_d = S_EXC;
                    exc_d   = 2'b10;
                end else begin
                    state_d = S_WB_I;
                end
            end
            S_EXC: state_d = S_FETCH;
`else
            S_EXEC_ADD, S_EXEC_SUB: state_d = S_WB_R;
            S_EXEC_I:               state_d = S_WB_I;
`endif
            S_EXEC_AND: state_d = S_WB_R;
            S_MADDR:    state_d = (OPCode == OP_SW) ? S_MWR : S_MRD;
            S_MRD: begin
                if (cnt_q == WAIT_LAST) state_d = S_WB_L;
                else                    cnt_d   = cnt_q + 3'd1;
            end
            S_WB_R, S_WB_I, S_WB_L, S_BR_EQ, S_BR_NE, S_JUMP, S_MWR:
                state_d = S_FETCH;
            default: state_d = S_RST;
        endcase

        // Undecodable instructions either trap or are dropped without any write.
        if (illegal_op) begin
`ifdef EXC_SUPPORT_EN
            state_d = S_EXC;
            exc_d   = 2'b01;
`else
            state_d = S_FETCH;
`endif
        end
    end

    // State, counter and registered outputs; reset wins over every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RST;
            cnt_q   <= 3'd0;
            ctrl_q  <= ctrl_for(S_RST);
`ifdef EXC_SUPPORT_EN
            exc_q   <= 2'b00;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_for(state_d);
`ifdef EXC_SUPPORT_EN
            exc_q   <= exc_d;
`endif
        end
    end

    assign PCWrite     = ctrl_q.pc_write;
    assign PCWriteCond = ctrl_q.pc_write_cond;
    assign BranchNe    = ctrl_q.branch_ne;
    assign PCSource    = ctrl_q.pc_source;
    assign IorD        = ctrl_q.iord;
    assign MemWrite    = ctrl_q.mem_write;
    assign IRWrite     = ctrl_q.ir_write;
    assign LoadA       = ctrl_q.load_a;
    assign LoadB       = ctrl_q.load_b;
    assign ALUOutWrite = ctrl_q.alu_out_write;
    assign ALUSrcA     = ctrl_q.alu_src_a;
    assign ALUSrcB     = ctrl_q.alu_src_b;
    assign ALUOp       = ctrl_q.alu_op;
    assign RegDst      = ctrl_q.reg_dst;
    assign MemToReg    = ctrl_q.mem_to_reg;
    assign RegWrite    = ctrl_q.reg_write;
    assign EPCWrite    = ctrl_q.epc_write;
    assign rst_out     = ctrl_q.rst_out;
`ifdef EXC_SUPPORT_EN
    assign exc_cause   = exc_q;
`else
    assign exc_cause   = 2'b00;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: two instances (MEM_WAIT=3 and MEM_WAIT=1) share inputs.
// Expected per-cycle output words are queued when an instruction is applied
// and popped/compared on each falling edge.
module tb_mc_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       of = 1'b0;

    always #5 clk = ~clk;

    // Instance A (MEM_WAIT=3) outputs
    logic a_pcw, a_pcwc, a_bne, a_mw, a_irw, a_la, a_lb, a_aow, a_asa, a_m2r, a_rw, a_epc, a_rst;
    logic [1:0] a_pcs, a_asb, a_rd, a_exc;
    logic [2:0] a_iord, a_aop;
    // Instance B (MEM_WAIT=1) outputs
    logic b_pcw, b_pcwc, b_bne, b_mw, b_irw, b_la, b_lb, b_aow, b_asa, b_m2r, b_rw, b_epc, b_rst;
    logic [1:0] b_pcs, b_asb, b_rd, b_exc;
    logic [2:0] b_iord, b_aop;

    mc_control_unit #(.MEM_WAIT(3)) dut_a (
        .clk(clk), .reset(reset), .OPCode(opcode), .Funct(funct), .Of(of),
        .PCWrite(a_pcw), .PCWriteCond(a_pcwc), .BranchNe(a_bne), .PCSource(a_pcs),
        .IorD(a_iord), .MemWrite(a_mw), .IRWrite(a_irw), .LoadA(a_la), .LoadB(a_lb),
        .ALUOutWrite(a_aow), .ALUSrcA(a_asa), .ALUSrcB(a_asb), .ALUOp(a_aop),
        .RegDst(a_rd), .MemToReg(a_m2r), .RegWrite(a_rw), .EPCWrite(a_epc),
        .exc_cause(a_exc), .rst_out(a_rst)
    );

    mc_control_unit #(.MEM_WAIT(1)) dut_b (
        .clk(clk), .reset(reset), .OPCode(opcode), .Funct(funct), .Of(of),
        .PCWrite(b_pcw), .PCWriteCond(b_pcwc), .BranchNe(b_bne), .PCSource(b_pcs),
        .IorD(b_iord), .MemWrite(b_mw), .IRWrite(b_irw), .LoadA(b_la), .LoadB(b_lb),
        .ALUOutWrite(b_aow), .ALUSrcA(b_asa), .ALUSrcB(b_asb), .ALUOp(b_aop),
        .RegDst(b_rd), .MemToReg(b_m2r), .RegWrite(b_rw), .EPCWrite(b_epc),
        .exc_cause(b_exc), .rst_out(b_rst)
    );

    logic [26:0] obs_a, obs_b;
    assign obs_a = {a_pcw, a_pcwc, a_bne, a_pcs, a_iord, a_mw, a_irw, a_la, a_lb, a_aow,
                    a_asa, a_asb, a_aop, a_rd, a_m2r, a_rw, a_epc, a_exc, a_rst};
    assign obs_b = {b_pcw, b_pcwc, b_bne, b_pcs, b_iord, b_mw, b_irw, b_la, b_lb, b_aow,
                    b_asa, b_asb, b_aop, b_rd, b_m2r, b_rw, b_epc, b_exc, b_rst};

    function automatic logic [26:0] mk(
        input logic pcw, pcwc, bne, input logic [1:0] pcs, input logic [2:0] iord,
        input logic mw, irw, la, lb, aow, asa, input logic [1:0] asb, input logic [2:0] aop,
        input logic [1:0] rd, input logic m2r, rw, epc, input logic [1:0] exc, input logic rst);
        return {pcw, pcwc, bne, pcs, iord, mw, irw, la, lb, aow, asa, asb, aop, rd, m2r, rw, epc, exc, rst};
    endfunction

    localparam logic O = 1'b0;
    localparam logic I = 1'b1;
    //                          pcw pcwc bne pcs   iord    mw irw la lb aow asa asb    aop     rd    m2r rw epc exc   rst
    localparam logic [26:0] E_RST   = mk(O, O, O, 2'b00, 3'b000, O, O, O, O, O, O, 2'b00, 3'b000, 2'b00, O, O, O, 2'b00, I);
    localparam logic [26:0] E_FETCH = mk(O, O, O, 2'b00, 3'b000, O, O, O, O, O, O, 2'b01, 3'b001, 2'b00, O, O, O, 2'b00, O);
    localparam logic [26:0] E_IRLD  = mk(I, O, O, 2'b00, 3'b000, O, I, O, O, O, O, 2'b01, 3'b001, 2'b00, O, O, O, 2'b00, O);
    localparam logic [26:0] E_DEC   = mk(O, O, O, 2'b00, 3'b000, O, O, I, I, I, O, 2'b11, 3'b001, 2'b00, O, O, O, 2'b00, O);
    localparam logic [26:0] E_ADD   = mk(O, O, O, 2'b00, 3'b000, O, O, O, O, I, I, 2'b00, 3'b001, 2'b00, O, O, O, 2'b00, O);
    localparam logic [26:0] E_SUB   = mk(O, O, O, 2'b00, 3'b000, O, O, O, O, I, I, 2'b00, 3'b010, 2'b00, O, O, O, 2'b00, O);
    localparam logic [26:0] E_AND   = mk(O, O, O, 2'b00, 3'b000, O, O, O, O, I, I, 2'b00, 3'b011, 2'b00, O, O, O, 2'b00, O);
    localparam logic [26:0] E_EXI   = mk(O, O, O, 2'b00, 3'b000, O, O, O, O, I, I, 2'b10, 3'b001, 2'b00, O, O, O, 2'b00, O);
    localparam logic [26:0] E_WBR   = mk(O, O, O, 2'b00, 3'b000, O, O, O, O, O, O, 2'b00, 3'b000, 2'b01, O, I, O, 2'b00, O);
    localparam logic [26:0] E_WBI   = mk(O, O, O, 2'b00, 3'b000, O, O, O, O, O, O, 2'b00, 3'b000, 2'b00, O, I, O, 2'b00, O);
    localparam logic [26:0] E_BEQ   = mk(O, I, O, 2'b01, 3'b000, O, O, O, O, O, I, 2'b00, 3'b010, 2'b00, O, O, O, 2'b00, O);
    localparam logic [26:0] E_BNE   = mk(O, I, I, 2'b01, 3'b000, O, O, O, O, O, I, 2'b00, 3'b010, 2'b00, O, O, O, 2'b00, O);
    localparam logic [26:0] E_JMP   = mk(I, O, O, 2'b10, 3'b000, O, O, O, O, O, O, 2'b00, 3'b000, 2'b00, O, O, O, 2'b00, O);
    localparam logic [26:0] E_MADDR = mk(O, O, O, 2'b00, 3'b000, O, O, O, O, I, I, 2'b10, 3'b001, 2'b00, O, O, O, 2'b00, O);
    localparam logic [26:0] E_MRD   = mk(O, O, O, 2'b00, 3'b001, O, O, O, O, O, O, 2'b00, 3'b000, 2'b00, O, O, O, 2'b00, O);
    localparam logic [26:0] E_WBL   = mk(O, O, O, 2'b00, 3'b000, O, O, O, O, O, O, 2'b00, 3'b000, 2'b00, I, I, O, 2'b00, O);
    localparam logic [26:0] E_MWR   = mk(O, O, O, 2'b00, 3'b001, I, O, O, O, O, O, 2'b00, 3'b000, 2'b00, O, O, O, 2'b00, O);
    localparam logic [26:0] E_EXC   = mk(I, O, O, 2'b11, 3'b000, O, O, O, O, O, O, 2'b00, 3'b000, 2'b00, O, O, I, 2'b00, O);

    int checks = 0;
    int errors = 0;
    logic [26:0] exp_a[$];
    logic [26:0] exp_b[$];
    logic [1:0]  sticky = 2'b00;   // exc_cause expected to persist after a trap
    logic [26:0] e;

    task automatic push_a(input logic [26:0] v);
        exp_a.push_back(v | {24'd0, sticky, 1'b0});
    endtask

    task automatic push_b(input logic [26:0] v);
        exp_b.push_back(v | {24'd0, sticky, 1'b0});
    endtask

    // RST, MEM_WAIT fetch cycles, IRLD, DECODE for instance A.
    task automatic push_front_a();
        push_a(E_RST);
        repeat (3) push_a(E_FETCH);
        push_a(E_IRLD);
        push_a(E_DEC);
    endtask

    // Leaves the bench on a falling edge inside the post-reset RST cycle (cycle 0).
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sticky = 2'b00;
        exp_a.delete();
        exp_b.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset  = 1'b1;
        opcode = 6'h02;
        funct  = 6'h00;
        of     = 1'b0;
        sticky = 2'b00;
        exp_a.delete();
        exp_b.delete();
        repeat (3) push_a(E_RST);
        repeat (3) push_a(E_FETCH);
        push_a(E_IRLD);
        repeat (3) push_b(E_RST);
        push_b(E_FETCH);
        push_b(E_IRLD);
        push_b(E_DEC);
        push_b(E_JMP);
        push_b(E_FETCH);
        for (int k = 0; exp_a.size() > 0 || exp_b.size() > 0; k++) begin
            @(negedge clk);
            if (exp_a.size() > 0) begin
                e = exp_a.pop_front(); checks++;
                if (obs_a !== e) begin errors++; $display("FAIL reset_a cyc %0d: got %h want %h", k, obs_a, e); end
            end
            if (exp_b.size() > 0) begin
                e = exp_b.pop_front(); checks++;
                if (obs_b !== e) begin errors++; $display("FAIL reset_b cyc %0d: got %h want %h", k, obs_b, e); end
            end
            if (k == 2) reset = 1'b0;
        end
    endtask

    task automatic test_add();
        opcode = 6'h00; funct = 6'h20; of = 1'b0;
        do_reset();
        push_front_a();
        push_a(E_ADD);      // cycle 6
        push_a(E_WBR);      // cycle 7
        push_a(E_FETCH);    // cycle 8
        for (int k = 0; exp_a.size() > 0; k++) begin
            if (k > 0) @(negedge clk);
            e = exp_a.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL add cyc %0d: got %h want %h", k, obs_a, e); end
        end
    endtask

    // SUB with no overflow; AND with Of=1 (AND never traps).
    task automatic test_sub_and();
        logic [5:0]  fn[2]  = '{6'h22, 6'h24};
        logic        ov[2]  = '{1'b0, 1'b1};
        logic [26:0] ex[2]  = '{E_SUB, E_AND};
        for (int t = 0; t < 2; t++) begin
            opcode = 6'h00; funct = fn[t]; of = ov[t];
            do_reset();
            push_front_a();
            push_a(ex[t]);
            push_a(E_WBR);
            push_a(E_FETCH);
            for (int k = 0; exp_a.size() > 0; k++) begin
                if (k > 0) @(negedge clk);
                e = exp_a.pop_front(); checks++;
                if (obs_a !== e) begin errors++; $display("FAIL rtype fn=%h cyc %0d: got %h want %h", fn[t], k, obs_a, e); end
            end
        end
    endtask

    task automatic test_addi_overflow();
        opcode = 6'h08; funct = 6'h3A; of = 1'b1;
        do_reset();
        push_front_a();
        push_a(E_EXI);
`ifdef EXC_SUPPORT_EN
        sticky = 2'b10;
        push_a(E_EXC);      // cycle 7
`else
        push_a(E_WBI);      // Of ignored without trap support
`endif
        push_a(E_FETCH);
        for (int k = 0; exp_a.size() > 0; k++) begin
            if (k > 0) @(negedge clk);
            e = exp_a.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL addi_of cyc %0d: got %h want %h", k, obs_a, e); end
        end
        of = 1'b0;
    endtask

    task automatic test_lw_sw();
        opcode = 6'h23; funct = 6'h00; of = 1'b0;
        do_reset();
        push_front_a();
        push_a(E_MADDR);
        repeat (3) push_a(E_MRD);   // cycles 7..9
        push_a(E_WBL);              // cycle 10
        push_a(E_FETCH);
        for (int k = 0; exp_a.size() > 0; k++) begin
            if (k > 0) @(negedge clk);
            e = exp_a.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL lw cyc %0d: got %h want %h", k, obs_a, e); end
        end
        opcode = 6'h2B;
        do_reset();
        push_front_a();
        push_a(E_MADDR);
        push_a(E_MWR);              // cycle 7
        repeat (3) push_a(E_FETCH);
        push_a(E_IRLD);
        for (int k = 0; exp_a.size() > 0; k++) begin
            if (k > 0) @(negedge clk);
            e = exp_a.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL sw cyc %0d: got %h want %h", k, obs_a, e); end
        end
    endtask

    task automatic test_branch();
        logic [5:0]  op[2] = '{6'h04, 6'h05};
        logic [26:0] ex[2] = '{E_BEQ, E_BNE};
        for (int t = 0; t < 2; t++) begin
            opcode = op[t]; funct = 6'h00; of = 1'b0;
            do_reset();
            push_front_a();
            push_a(ex[t]);      // cycle 6
            push_a(E_FETCH);
            push_b(E_RST);
            push_b(E_FETCH);
            push_b(E_IRLD);
            push_b(E_DEC);
            push_b(ex[t]);      // cycle 4
            push_b(E_FETCH);
            for (int k = 0; exp_a.size() > 0 || exp_b.size() > 0; k++) begin
                if (k > 0) @(negedge clk);
                if (exp_a.size() > 0) begin
                    e = exp_a.pop_front(); checks++;
                    if (obs_a !== e) begin errors++; $display("FAIL branch_a op=%h cyc %0d: got %h want %h", op[t], k, obs_a, e); end
                end
                if (exp_b.size() > 0) begin
                    e = exp_b.pop_front(); checks++;
                    if (obs_b !== e) begin errors++; $display("FAIL branch_b op=%h cyc %0d: got %h want %h", op[t], k, obs_b, e); end
                end
            end
        end
    endtask

    task automatic test_illegal();
        logic [5:0] op[2] = '{6'h3E, 6'h00};
        logic [5:0] fn[2] = '{6'h20, 6'h21};
        for (int t = 0; t < 2; t++) begin
            opcode = op[t]; funct = fn[t]; of = 1'b0;
            do_reset();
            push_front_a();
`ifdef EXC_SUPPORT_EN
            sticky = 2'b01;
            push_a(E_EXC);
`endif
            repeat (3) push_a(E_FETCH);
            push_a(E_IRLD);
            for (int k = 0; exp_a.size() > 0; k++) begin
                if (k > 0) @(negedge clk);
                e = exp_a.pop_front(); checks++;
                if (obs_a !== e) begin errors++; $display("FAIL illegal op=%h fn=%h cyc %0d: got %h want %h", op[t], fn[t], k, obs_a, e); end
            end
        end
    endtask

    task automatic test_rst_opcode();
        opcode = 6'h3F; funct = 6'h00; of = 1'b0;
        do_reset();
        push_front_a();
        push_a(E_RST);      // cycle 6, exactly one
        push_a(E_FETCH);
        push_a(E_FETCH);
        for (int k = 0; exp_a.size() > 0; k++) begin
            if (k > 0) @(negedge clk);
            e = exp_a.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL op3f cyc %0d: got %h want %h", k, obs_a, e); end
        end
    endtask

    task automatic test_reset_mid_mrd();
        opcode = 6'h23; funct = 6'h00; of = 1'b0;
        do_reset();
        push_front_a();
        push_a(E_MADDR);
        push_a(E_MRD);      // cycle 7
        push_a(E_MRD);      // cycle 8: reset raised here
        push_a(E_RST);      // cycle 9
        push_a(E_FETCH);    // cycle 10
        for (int k = 0; exp_a.size() > 0; k++) begin
            if (k > 0) @(negedge clk);
            e = exp_a.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL mid_mrd_reset cyc %0d: got %h want %h", k, obs_a, e); end
            if (k == 8) reset = 1'b1;
            if (k == 9) reset = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        opcode = 6'h00; funct = 6'h20; of = 1'b0;
        do_reset();
        push_front_a();
        push_a(E_ADD);
        push_a(E_WBR);      // cycle 7: next instruction presented
        repeat (3) push_a(E_FETCH);
        push_a(E_IRLD);
        push_a(E_DEC);
        push_a(E_JMP);
        push_a(E_FETCH);
        for (int k = 0; exp_a.size() > 0; k++) begin
            if (k > 0) @(negedge clk);
            e = exp_a.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL back_to_back cyc %0d: got %h want %h", k, obs_a, e); end
            if (k == 7) opcode = 6'h02;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_and();
        test_addi_overflow();
        test_lw_sw();
        test_branch();
        test_illegal();
        test_rst_opcode();
        test_reset_mid_mrd();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
